rope_line_raster: RTL and testbench
===================================

Name: rope_line_raster

Overview:
- Downstream consumer of the rope solver's node coordinate buses.
- On each frame-start pulse it snapshots all node positions.
- It then walks the NODE_COUNT-1 segments between consecutive nodes using integer Bresenham, emitting one pixel coordinate per accepted handshake toward the framebuffer writer.
- It sits between the rope solver and the VGA framebuffer/pixel-write port.

Parameters:
- NODE_COUNT, 20, number of rope nodes (cores × 5); must be ≥ 2.
- H_RES, 640, horizontal visible resolution; pixels with x ≥ H_RES are clipped.
- V_RES, 480, vertical visible resolution; pixels with y ≥ V_RES are clipped.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- nodes_x  input  NODE_COUNT*10  packed node x coordinates; node k at bits [k*10+9 : k*10], unsigned pixels.
- nodes_y  input  NODE_COUNT*10  packed node y coordinates; same packing as nodes_x.
- start  input  1  frame-start strobe (e.g. vsync edge); honoured only in IDLE.
- pix_ready  input  1  framebuffer can accept a pixel this cycle.
- pix_valid  output  1  pix_x/pix_y hold a visible pixel to write.
- pix_x  output  10  pixel column.
- pix_y  output  10  pixel row.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last segment completes.

Behaviour:
- Reset (sync) state:
  - FSM = IDLE.
  - pix_valid, busy, done = 0.
  - pix_x, pix_y = 0.
  - Segment index, error register and snapshot registers = 0.
  - Reset has priority over every other event, including mid-segment and mid-handshake; no further pixels are emitted after the reset edge.
- FSM states: IDLE, SETUP, DRAW, FIN.
- IDLE:
  - On start=1: latch nodes_x/nodes_y into snapshot registers, seg = 0, go to SETUP.
  - start in any other state is ignored (not queued).
  - Solver updates after the latch never affect the frame being drawn.
- SETUP (1 cycle), for segment seg:
  - Endpoints: a = node seg, b = node seg+1.
  - x = xa, y = ya.
  - dx = |xb-xa|, dy = -|yb-ya|.
  - sx = +1 if xa < xb else -1; sy = +1 if ya < yb else -1.
  - err = dx + dy.
  - Go to DRAW.
- Width rules:
  - dx, dy, err are 12-bit two's complement.
  - e2 = 2*err is 13-bit signed.
  - No overflow is possible for 10-bit coordinates.
- DRAW, current pixel (x, y):
  - visible = (x < H_RES) && (y < V_RES).
  - pix_valid = visible; pix_x/pix_y = x/y. Outputs are registered and change only on advance.
  - advance = (visible && pix_ready) || !visible. Clipped pixels advance without a handshake, one per cycle.
  - While pix_valid=1 && pix_ready=0, pix_x/pix_y/pix_valid are held stable.
  - On advance, if x == xb && y == yb (segment end):
    - If seg == NODE_COUNT-2, go to FIN.
    - Else seg++ and go to SETUP.
  - On advance otherwise, compute e2 from the pre-update err:
    - If e2 ≥ dy: err += dy, x += sx.
    - If e2 ≤ dx: err += dx, y += sy.
    - Both may apply in the same cycle (err += dx+dy).
  - pix_valid is 0 in SETUP, FIN and IDLE.
- FIN: done = 1 for exactly one cycle, then IDLE. busy is 1 in FIN and drops to 0 with IDLE.
- Shared endpoints: the endpoint between segments k and k+1 is emitted twice (last pixel of k, first pixel of k+1). This is intentional; the writer is idempotent.
- Zero-length segment (a == b): exactly one pixel, then the segment ends.
- Latency, with pix_ready held 1:
  - start seen at edge N → SETUP in cycle N+1 → first pix_valid in cycle N+2.
  - Each further pixel takes 1 cycle; each segment adds 1 SETUP cycle.
- Total pixel count with no clipping: sum over segments of (max(dx, |dy|) + 1).

Test Plan:
1. NODE_COUNT=3, nodes (10,10),(13,10),(13,12), start pulse, pix_ready=1 → pixels exactly (10,10),(11,10),(12,10),(13,10),(13,10),(13,11),(13,12); first pix_valid 2 cycles after start; done pulses once; busy then falls.
2. NODE_COUNT=2, (0,0)→(3,3), then (5,1)→(0,3) → diagonal yields (0,0),(1,1),(2,2),(3,3). Reverse shallow line yields (5,1),(4,1),(3,2),(2,2),(1,3),(0,3): 6 pixels with negative steps, matching a golden Bresenham model.
3. Backpressure: scenario 1 with pix_ready toggling in a 1-0-0-1 pattern → identical pixel sequence; pix_x/pix_y stable whenever pix_valid=1 and pix_ready=0; no drops or duplicates beyond the shared endpoint.
4. Clipping: (636,5)→(642,5), H_RES=640 → only (636..639,5) asserted with pix_valid; 3 clipped steps consume 1 cycle each with pix_valid=0; done still fires.
5. Snapshot/ignore: change nodes_x and pulse start again while busy → drawn pixels match the first snapshot; no second frame starts; after done, a new start uses the new values.
6. Reset mid-DRAW after 2 pixels of scenario 1 → next cycle pix_valid=0, busy=0, done=0, pix_x=pix_y=0; a subsequent start redraws the full sequence from (10,10).

Source files
------------

// File: rtl/rope_line_raster.sv
// rope_line_raster: on start, snapshots rope node coordinates and Bresenham-walks each segment, emitting visible pixels over valid/ready (in: clk, reset, nodes_x/y, start, pix_ready; out: pix_valid, pix_x/y, busy, done)
module rope_line_raster #(
  parameter int NODE_COUNT = 20,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NODE_COUNT*10-1:0] nodes_x,
  input  logic [NODE_COUNT*10-1:0] nodes_y,
  input  logic                     start,
  input  logic                     pix_ready,
  output logic                     pix_valid,
  output logic [9:0]               pix_x,
  output logic [9:0]               pix_y,
  output logic                     busy,
  output logic                     done
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2, FIN = 2'd3;
  localparam int SW = NODE_COUNT > 2 ? $clog2(NODE_COUNT - 1) : 1;
  localparam int W = NODE_COUNT * 10;
  logic [1:0] state_q, state_d;
  logic [W-1:0] snx_q, snx_d, sny_q, sny_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [9:0] x_q, x_d, y_q, y_d, xb_q, xb_d, yb_q, yb_d;
  logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic sxn_q, sxn_d, syn_q, syn_d;
  logic [31:0] sa;
  logic [9:0] xa, ya, xe, ye, adx, ady;
  logic signed [12:0] e2;
  logic vis, adv, stx, sty, last, fin_seg;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snx_q   <= '0;
      sny_q   <= '0;
      seg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snx_q   <= snx_d;
      sny_q   <= sny_d;
      seg_q   <= seg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end
  always_comb begin
    sa      = 32'(seg_q) * 10;
    xa      = snx_q[sa +: 10];
    ya      = sny_q[sa +: 10];
    xe      = snx_q[sa + 10 +: 10];
    ye      = sny_q[sa + 10 +: 10];
    adx     = xa < xe ? xe - xa : xa - xe;
    ady     = ya < ye ? ye - ya : ya - ye;
    vis     = 32'(x_q) < H_RES && 32'(y_q) < V_RES;
    adv     = !vis || pix_ready;
    e2      = {err_q, 1'b0};
    stx     = e2 >= 13'(dy_q);
    sty     = e2 <= 13'(dx_q);
    last    = x_q == xb_q && y_q == yb_q;
    fin_seg = 32'(seg_q) == NODE_COUNT - 2;
    state_d = state_q;
    snx_d   = snx_q;
    sny_d   = sny_q;
    seg_d   = seg_q;
    x_d     = x_q;
    y_d     = y_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        snx_d   = nodes_x;
        sny_d   = nodes_y;
        seg_d   = '0;
      end
      SETUP: begin
        state_d = DRAW;
        x_d     = xa;
        y_d     = ya;
        xb_d    = xe;
        yb_d    = ye;
        dx_d    = 12'(adx);
        dy_d    = -12'(ady);
        err_d   = 12'(adx) - 12'(ady);
        sxn_d   = !(xa < xe);
        syn_d   = !(ya < ye);
      end
      DRAW: if (adv) begin
        if (last) begin
          state_d = fin_seg ? FIN : SETUP;
          seg_d   = fin_seg ? seg_q : seg_q + 1'b1;
        end else begin
          err_d = err_q + (stx ? dy_q : 12'sd0) + (sty ? dx_q : 12'sd0);
          x_d   = stx ? (sxn_q ? x_q - 10'd1 : x_q + 10'd1) : x_q;
          y_d   = sty ? (syn_q ? y_q - 10'd1 : y_q + 10'd1) : y_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign pix_valid = state_q == DRAW && vis;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == FIN;
endmodule

// File: tb/tb_rope_line_raster.sv
// tb_rope_line_raster: directed scoreboard bench for rope_line_raster with three nodes
module tb_rope_line_raster;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [29:0] nodes_x = '0;
  logic [29:0] nodes_y = '0;
  logic start = 1'b0;
  logic pix_ready = 1'b1;
  logic pix_valid, busy, done;
  logic [9:0] pix_x, pix_y;
  int n_chk = 0;
  int n_fail = 0;
  int pops = 0;
  int rc = 0;
  bit bp = 1'b0;
  int sb[$];
  rope_line_raster #(.NODE_COUNT(3), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset(reset), .nodes_x(nodes_x), .nodes_y(nodes_y), .start(start),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input int x, input int y);
    sb.push_back(x * 1000 + y);
  endtask
  task automatic set_nodes(input int x0, y0, x1, y1, x2, y2);
    nodes_x = {10'(x2), 10'(x1), 10'(x0)};
    nodes_y = {10'(y2), 10'(y1), 10'(y0)};
  endtask
  task automatic push_s1(input int o);
    push(10 + o, 10); push(11 + o, 10); push(12 + o, 10); push(13 + o, 10);
    push(13 + o, 10); push(13 + o, 11); push(13 + o, 12);
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input int exp_cyc, input int exp_first);
    int cyc = 0;
    int first = -1;
    bit seen = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (pix_valid && first < 0) first = i;
      seen = done;
    end
    chk("done_seen", int'(seen), 1);
    if (exp_cyc >= 0) chk("done_cycle", cyc, exp_cyc);
    if (exp_first >= 0) chk("first_valid_cycle", first, exp_first);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial forever begin
    @(posedge clk); #1;
    rc++;
    pix_ready = !bp || rc % 4 == 0 || rc % 4 == 3;
  end
  initial begin
    bit hold = 1'b0;
    logic [9:0] hx = '0, hy = '0;
    forever begin
      @(negedge clk);
      if (reset) hold = 1'b0;
      else begin
        if (hold) begin
          chk("hold_valid", int'(pix_valid), 1);
          chk("hold_x", int'(pix_x), int'(hx));
          chk("hold_y", int'(pix_y), int'(hy));
        end
        hold = pix_valid && !pix_ready;
        hx = pix_x;
        hy = pix_y;
        if (pix_valid && pix_ready) begin
          if (sb.size() == 0) chk("unexpected_pixel", int'(pix_x) * 1000 + int'(pix_y), -1);
          else chk("pixel", int'(pix_x) * 1000 + int'(pix_y), sb.pop_front());
          pops++;
        end
      end
    end
  end
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), 0);
    set_nodes(10, 10, 13, 10, 13, 12);
    push_s1(0);
    pulse_start();
    chk("setup_valid", int'(pix_valid), 0);
    chk("setup_busy", int'(busy), 1);
    wait_done(9, 1);
    set_nodes(0, 0, 3, 3, 3, 3);
    push(0, 0); push(1, 1); push(2, 2); push(3, 3); push(3, 3);
    pulse_start();
    wait_done(7, 1);
    set_nodes(5, 1, 0, 3, 0, 3);
    push(5, 1); push(4, 1); push(3, 2); push(2, 2); push(1, 3); push(0, 3); push(0, 3);
    pulse_start();
    wait_done(9, 1);
    bp = 1'b1;
    set_nodes(10, 10, 13, 10, 13, 12);
    push_s1(0);
    pulse_start();
    wait_done(-1, -1);
    bp = 1'b0;
    set_nodes(636, 5, 642, 5, 642, 5);
    push(636, 5); push(637, 5); push(638, 5); push(639, 5);
    pulse_start();
    wait_done(10, 1);
    set_nodes(10, 10, 13, 10, 13, 12);
    push_s1(0);
    pulse_start();
    repeat (2) @(posedge clk);
    #1 set_nodes(110, 10, 113, 10, 113, 12);
    pulse_start();
    wait_done(-1, -1);
    repeat (5) @(posedge clk);
    #1 chk("no_second_frame", int'(busy), 0);
    push_s1(100);
    pulse_start();
    wait_done(9, 1);
    set_nodes(10, 10, 13, 10, 13, 12);
    push_s1(0);
    base = pops;
    pulse_start();
    for (int i = 0; i < 50 && pops < base + 2; i++) @(negedge clk);
    chk("two_pixels_before_reset", pops - base, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_valid", int'(pix_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_x", int'(pix_x), 0);
    chk("mid_rst_y", int'(pix_y), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    push_s1(0);
    pulse_start();
    wait_done(9, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
